// File: rtl/pipe_pkg.sv
// Shared definitions for the memory-stage skid buffer: state encoding and default widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skidState_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 6;
    localparam int DEF_REG_W  = 5;
    localparam int DEF_FWD_N  = 2;

endpackage

// File: rtl/pipe_fwd_mux.sv
// Store-data forwarding select: the lowest-index requesting source wins,
// falling back to the un-forwarded register value when nobody requests.
module pipe_fwd_mux #(
    parameter int DATA_W = 32,
    parameter int FWD_N  = 2
) (
    input  logic [DATA_W-1:0]       baseData,
    input  logic [FWD_N-1:0]        fwdSel,
    input  logic [FWD_N*DATA_W-1:0] fwdData,
    output logic [DATA_W-1:0]       selData
);

    // Walk from the highest source down so the lowest asserted index overrides last.
    always_comb begin
        selData = baseData;
        for (int k = FWD_N - 1; k >= 0; k--) begin
            if (fwdSel[k]) begin
                selData = fwdData[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer between execute and memory: in_ready is registered state only,
// so upstream never sees a combinational path from the downstream stall.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int FWD_N  = DEF_FWD_N
) (
    input  logic                    CLOCK,
    input  logic                    RESET,
    input  logic                    FLUSH,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_alu_result,
    input  logic [DATA_W-1:0]       in_mem_wdata,
    input  logic [CTRL_W-1:0]       in_mem_ctrl,
    input  logic                    in_mem_read,
    input  logic                    in_mem_write,
    input  logic [REG_W-1:0]        in_wreg,
    input  logic                    in_wen,
    input  logic [FWD_N-1:0]        fwd_sel,
    input  logic [FWD_N*DATA_W-1:0] fwd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_alu_result,
    output logic [DATA_W-1:0]       out_mem_wdata,
    output logic [CTRL_W-1:0]       out_mem_ctrl,
    output logic                    out_mem_read,
    output logic                    out_mem_write,
    output logic [REG_W-1:0]        out_wreg,
    output logic                    out_wen,
    output logic [1:0]              occupancy
);

    localparam int ENTRY_W = 2*DATA_W + CTRL_W + REG_W + 3;

    skidState_t         state, stateNext;
    logic [ENTRY_W-1:0] headEntry, headNext;
    logic [ENTRY_W-1:0] skidEntry, skidNext;
    logic [ENTRY_W-1:0] inEntry;
    logic [DATA_W-1:0]  fwdWdata;
    logic               push, pop;
    logic               headRead, headWrite, headWen;

    pipe_fwd_mux #(
        .DATA_W(DATA_W),
        .FWD_N (FWD_N)
    ) fwdMux (
        .baseData(in_mem_wdata),
        .fwdSel  (fwd_sel),
        .fwdData (fwd_data),
        .selData (fwdWdata)
    );

    assign inEntry = {in_alu_result, fwdWdata, in_mem_ctrl, in_mem_read,
                      in_mem_write, in_wreg, in_wen};

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign occupancy = 2'(state);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state     <= EMPTY;
            headEntry <= '0;
            skidEntry <= '0;
        end else begin
            state     <= stateNext;
            headEntry <= headNext;
            skidEntry <= skidNext;
        end
    end

    // FLUSH beats everything, including an input transfer on the same edge.
    always_comb begin
        stateNext = state;
        headNext  = headEntry;
        skidNext  = skidEntry;
        if (FLUSH) begin
            stateNext = EMPTY;
            headNext  = '0;
            skidNext  = '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (push) begin
                        headNext  = inEntry;
                        stateNext = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        headNext = inEntry;
                    end else if (push) begin
                        skidNext  = inEntry;
                        stateNext = FULL;
                    end else if (pop) begin
                        stateNext = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        headNext  = skidEntry;
                        stateNext = ONE;
                    end
                end
                default: begin
                    stateNext = EMPTY;
                end
            endcase
        end
    end

    assign {out_alu_result, out_mem_wdata, out_mem_ctrl, headRead, headWrite,
            out_wreg, headWen} = headEntry;

    // Command bits become a bubble whenever there is no head entry.
    assign out_mem_read  = headRead  & out_valid;
    assign out_mem_write = headWrite & out_valid;
    assign out_wen       = headWen   & out_valid;

endmodule
